lit_group: RTL and testbench

- Parametrised literal group for the SAT engine clause array; holds NUM_LITS literal slots of one clause segment.
- Evaluates the slots against the incoming variable values, continues the free-literal-count chain and drives a unit implication onto var_value_o.
- Reports registered clause-satisfied and conflict-participation status.
- Chains with other groups to form a clause of any length; adds per-slot addressed loading, clear, a status-valid flag and optional activity counting.

---
 rtl/sat_pkg.sv | 27 ++
 rtl/lit_slot.sv | 49 ++++
 rtl/lit_group.sv | 130 +++++++++++++
 tb/tb_lit_group.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Shared encodings and helpers for the SAT engine clause array.
// Literal codes, variable value codes, the implied-flag bit position
// and a saturating adder used by the free-literal-count chain.
package sat_pkg;

   localparam logic [1:0] LIT_NONE  = 2'b00;
   localparam logic [1:0] LIT_POS   = 2'b01;
   localparam logic [1:0] LIT_NEG   = 2'b10;

   localparam logic [1:0] VAL_FREE  = 2'b00;
   localparam logic [1:0] VAL_TRUE  = 2'b01;
   localparam logic [1:0] VAL_FALSE = 2'b10;

   localparam int IMP_BIT = 2;

   // a + b clipped to 2^width-1 (width < 32)
   function automatic int unsigned sat_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned width);
      int unsigned sum;
      int unsigned lim;
      sum = a + b;
      lim = (32'd1 << width) - 32'd1;
      return (sum > lim) ? lim : sum;
   endfunction

endpackage

// File: rtl/lit_slot.sv
// One literal slot: stored literal register, literal/value decode and implication override.
// Ports: clk/rst, wr/clr/lit_wr (slot load), val_in/val_out (3-bit variable value),
//        imp_sel (override this slot), lit (stored code), free/sat/fls decode flags.
module lit_slot
   import sat_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       wr,
   input  logic       clr,
   input  logic [1:0] lit_wr,
   input  logic [2:0] val_in,
   input  logic       imp_sel,
   output logic [1:0] lit,
   output logic       free,
   output logic       sat,
   output logic       fls,
   output logic [2:0] val_out
);

   logic [1:0] lit_q;
   logic       pos;
   logic       neg;
   logic [1:0] v;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         lit_q <= LIT_NONE;
      else if (clr)
         lit_q <= LIT_NONE;
      else if (wr)
         lit_q <= (lit_wr == 2'b11) ? LIT_NONE : lit_wr;
   end

   assign lit  = lit_q;
   assign pos  = (lit_q == LIT_POS);
   assign neg  = (lit_q == LIT_NEG);
   assign v    = val_in[1:0];

   // value code 11 counts as unassigned
   assign free = (pos | neg) && ((v == VAL_FREE) || (v == 2'b11));
   assign sat  = (pos && (v == VAL_TRUE))  || (neg && (v == VAL_FALSE));
   assign fls  = (pos && (v == VAL_FALSE)) || (neg && (v == VAL_TRUE));

   // imp_sel is only raised on a free slot, so lit_q is POS or NEG here and
   // doubles as the value that satisfies the literal
   assign val_out = imp_sel ? {1'b1, lit_q} : val_in;

endmodule

// File: rtl/lit_group.sv
// Literal group: NUM_LITS slots of a clause segment, free-count chain, unit implication, status.
// Ports: clk/rst; var_value_i/o (3 bits per slot); wr_i/wr_idx_i/lit_wr_i/clr_i slot load; lit_o;
//        freelitcnt_pre/next chain; imp_drv_i, cclause_drv_i; cclause_o, clausesat_o, valid_o.
// Optional macro LIT_GROUP_ACT_EN adds ACT_W, act_clr_i and act_o (saturating conflict activity).
module lit_group
   import sat_pkg::*;
#(
   parameter  int NUM_LITS = 8,
   parameter  int CNT_W    = 2,
`ifdef LIT_GROUP_ACT_EN
   parameter  int ACT_W    = 8,
`endif
   localparam int IDX_W    = (NUM_LITS > 1) ? $clog2(NUM_LITS) : 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3*NUM_LITS-1:0] var_value_i,
   output logic [3*NUM_LITS-1:0] var_value_o,
   input  logic                  wr_i,
   input  logic [IDX_W-1:0]      wr_idx_i,
   input  logic [1:0]            lit_wr_i,
   input  logic                  clr_i,
   output logic [2*NUM_LITS-1:0] lit_o,
   input  logic [CNT_W-1:0]      freelitcnt_pre,
   output logic [CNT_W-1:0]      freelitcnt_next,
   input  logic                  imp_drv_i,
   input  logic                  cclause_drv_i,
   output logic                  cclause_o,
   output logic                  clausesat_o,
   output logic                  valid_o
`ifdef LIT_GROUP_ACT_EN
   ,
   input  logic                  act_clr_i,
   output logic [ACT_W-1:0]      act_o
`endif
);

   localparam int LC_W = $clog2(NUM_LITS + 1);

   logic [NUM_LITS-1:0] free;
   logic [NUM_LITS-1:0] sat;
   logic [NUM_LITS-1:0] fls;
   logic [NUM_LITS-1:0] implied;
   logic [NUM_LITS-1:0] imp_sel;
   logic [LC_W-1:0]     local_cnt;
   logic                wr_ok;
   logic                accepted;
   logic                cc_cond;
   logic                found;
   logic                init_q;
   logic                valid_q;
   logic                clausesat_q;
   logic                cclause_q;

   // out-of-range indices are dropped and do not disturb valid_o
   assign wr_ok    = wr_i && (32'(wr_idx_i) < NUM_LITS);
   assign accepted = clr_i | wr_ok;

   for (genvar i = 0; i < NUM_LITS; i++) begin : g_slot
      assign implied[i] = var_value_i[3*i+IMP_BIT];
      lit_slot u_slot (
         .clk     (clk),
         .rst     (rst),
         .wr      (wr_ok && (wr_idx_i == IDX_W'(i))),
         .clr     (clr_i),
         .lit_wr  (lit_wr_i),
         .val_in  (var_value_i[3*i +: 3]),
         .imp_sel (imp_sel[i]),
         .lit     (lit_o[2*i +: 2]),
         .free    (free[i]),
         .sat     (sat[i]),
         .fls     (fls[i]),
         .val_out (var_value_o[3*i +: 3])
      );
   end

   // lowest-index free slot receives the implication; local free count
   always_comb begin
      imp_sel   = '0;
      found     = 1'b0;
      local_cnt = '0;
      for (int i = 0; i < NUM_LITS; i++) begin
         local_cnt = local_cnt + LC_W'(free[i]);
         if (imp_drv_i && free[i] && !found) begin
            imp_sel[i] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   assign freelitcnt_next = CNT_W'(sat_add(32'(freelitcnt_pre), 32'(local_cnt), CNT_W));

   assign cc_cond = cclause_drv_i && |(fls & implied);

   // status samples the pre-write slots; valid_o needs one quiet edge after
   // the reset-release edge (init_q) or after any accepted slot change
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         init_q      <= 1'b0;
         valid_q     <= 1'b0;
         clausesat_q <= 1'b0;
         cclause_q   <= 1'b0;
      end else begin
         init_q      <= 1'b1;
         valid_q     <= init_q && !accepted;
         clausesat_q <= |sat;
         cclause_q   <= cc_cond;
      end
   end

   assign valid_o     = valid_q;
   assign clausesat_o = clausesat_q;
   assign cclause_o   = cclause_q;

`ifdef LIT_GROUP_ACT_EN
   logic [ACT_W-1:0] act_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         act_q <= '0;
      else if (act_clr_i)
         act_q <= '0;
      else if (cc_cond && !(&act_q))
         act_q <= act_q + 1'b1;
   end

   assign act_o = act_q;
`endif

endmodule

// File: tb/tb_lit_group.sv
module tb_lit_group;

   localparam int N  = 5;
   localparam int CW = 2;
   localparam int AW = 2;
   localparam int IW = 3;
   localparam int CMAX = (1 << CW) - 1;

   logic            clk = 1'b0;
   logic            rst;
   logic [3*N-1:0]  var_value_i;
   logic [3*N-1:0]  var_value_o;
   logic            wr_i;
   logic [IW-1:0]   wr_idx_i;
   logic [1:0]      lit_wr_i;
   logic            clr_i;
   logic [2*N-1:0]  lit_o;
   logic [CW-1:0]   freelitcnt_pre;
   logic [CW-1:0]   freelitcnt_next;
   logic            imp_drv_i;
   logic            cclause_drv_i;
   logic            cclause_o;
   logic            clausesat_o;
   logic            valid_o;
   logic            act_clr_i;
`ifdef LIT_GROUP_ACT_EN
   logic [AW-1:0]   act_o;
`endif

   always #5 clk = ~clk;

   lit_group #(
      .NUM_LITS (N),
`ifdef LIT_GROUP_ACT_EN
      .ACT_W    (AW),
`endif
      .CNT_W    (CW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .var_value_i     (var_value_i),
      .var_value_o     (var_value_o),
      .wr_i            (wr_i),
      .wr_idx_i        (wr_idx_i),
      .lit_wr_i        (lit_wr_i),
      .clr_i           (clr_i),
      .lit_o           (lit_o),
      .freelitcnt_pre  (freelitcnt_pre),
      .freelitcnt_next (freelitcnt_next),
      .imp_drv_i       (imp_drv_i),
      .cclause_drv_i   (cclause_drv_i),
      .cclause_o       (cclause_o),
      .clausesat_o     (clausesat_o),
`ifdef LIT_GROUP_ACT_EN
      .act_clr_i       (act_clr_i),
      .act_o           (act_o),
`endif
      .valid_o         (valid_o)
   );

   int errors = 0;
   int checks = 0;

   // behavioural model state
   int m_lit [N];
   bit m_sat, m_cc, m_valid;
   int m_edges;
   int m_act;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_lit[i] = 0;
      m_sat = 0; m_cc = 0; m_valid = 0; m_edges = 0; m_act = 0;
   endtask

   // slot classification from literal polarity and variable value
   function automatic int val_of(input int i);
      logic [3*N-1:0] t;
      t = var_value_i;
      return int'(t[3*i +: 2]);
   endfunction

   function automatic bit imp_of(input int i);
      logic [3*N-1:0] t;
      t = var_value_i;
      return t[3*i+2];
   endfunction

   task automatic check_all();
      int nfree, first, expcnt;
      logic [3*N-1:0] exp_vo;
      logic [2*N-1:0] exp_lit;
      nfree  = 0;
      first  = -1;
      exp_vo = var_value_i;
      for (int i = 0; i < N; i++) begin
         exp_lit[2*i +: 2] = 2'(m_lit[i]);
         if (m_lit[i] != 0 && (val_of(i) == 0 || val_of(i) == 3)) begin
            nfree++;
            if (first < 0) first = i;
         end
      end
      if (imp_drv_i && first >= 0) exp_vo[3*first +: 3] = {1'b1, 2'(m_lit[first])};
      expcnt = int'(freelitcnt_pre) + nfree;
      if (expcnt > CMAX) expcnt = CMAX;
      chk("lit_o", 32'(lit_o), 32'(exp_lit));
      chk("freelitcnt_next", 32'(freelitcnt_next), 32'(expcnt));
      chk("var_value_o", 32'(var_value_o), 32'(exp_vo));
      chk("clausesat_o", 32'(clausesat_o), 32'(m_sat));
      chk("cclause_o", 32'(cclause_o), 32'(m_cc));
      chk("valid_o", 32'(valid_o), 32'(m_valid));
`ifdef LIT_GROUP_ACT_EN
      chk("act_o", 32'(act_o), 32'(m_act));
`endif
   endtask

   task automatic model_edge();
      bit anysat, anyfi, acc;
      int v, l;
      anysat = 0;
      anyfi  = 0;
      for (int i = 0; i < N; i++) begin
         v = val_of(i);
         l = m_lit[i];
         if (l != 0 && v == l) anysat = 1;
         if (l != 0 && v == 3 - l && imp_of(i)) anyfi = 1;
      end
      acc     = clr_i || (wr_i && int'(wr_idx_i) < N);
      m_sat   = anysat;
      m_cc    = cclause_drv_i && anyfi;
      m_valid = (m_edges >= 1) && !acc;
      m_edges++;
      if (act_clr_i) m_act = 0;
      else if (cclause_drv_i && anyfi && m_act < (1 << AW) - 1) m_act++;
      if (clr_i) begin
         for (int i = 0; i < N; i++) m_lit[i] = 0;
      end else if (wr_i && int'(wr_idx_i) < N) begin
         m_lit[wr_idx_i] = (lit_wr_i == 2'b11) ? 0 : int'(lit_wr_i);
      end
   endtask

   // called right after a negedge with inputs applied; returns at next negedge
   task automatic step();
      #1;
      if (!rst) model_reset();
      check_all();
      if (rst) model_edge();
      @(negedge clk);
   endtask

   initial begin
      logic [1:0] wlits [4];
      wlits[0] = 2'b01; wlits[1] = 2'b10; wlits[2] = 2'b00; wlits[3] = 2'b01;

      rst = 1'b0; wr_i = 0; wr_idx_i = '0; lit_wr_i = '0; clr_i = 0;
      var_value_i = '0; freelitcnt_pre = '0; imp_drv_i = 0; cclause_drv_i = 0; act_clr_i = 0;
      model_reset();
      @(negedge clk);
      step(); step();
      chk("reset_valid", 32'(valid_o), 32'd0);
      rst = 1'b1;
      step(); step();
      chk("valid_after_reset", 32'(valid_o), 32'd1);

      // directed: load slots 0..3
      for (int i = 0; i < 4; i++) begin
         wr_i = 1; wr_idx_i = IW'(i); lit_wr_i = wlits[i];
         step();
         wr_i = 0;
         #1 chk("valid_drop", 32'(valid_o), 32'd0);
      end
      step();
      chk("valid_return", 32'(valid_o), 32'd1);
      chk("lit_o_loaded", 32'(lit_o), 32'b00_01_00_10_01);

      var_value_i = '0;
      var_value_i[2:0] = 3'b010;
      var_value_i[5:3] = 3'b001;
      #1;
      chk("freecnt_one", 32'(freelitcnt_next), 32'd1);
      chk("clausesat_zero", 32'(clausesat_o), 32'd0);
      step();
      chk("clausesat_still_zero", 32'(clausesat_o), 32'd0);

      imp_drv_i = 1;
      #1;
      chk("imp_slot3", 32'(var_value_o[11:9]), 32'b101);
      chk("imp_pass", 32'(var_value_o[8:0]), 32'(var_value_i[8:0]));
      step();
      imp_drv_i = 0;

      var_value_i[2:0] = 3'b001;
      step();
      chk("clausesat_one", 32'(clausesat_o), 32'd1);

      var_value_i[2:0] = 3'b000;
      freelitcnt_pre = 2'd3;
      #1 chk("freecnt_sat", 32'(freelitcnt_next), 32'd3);
      freelitcnt_pre = 2'd0;
      #1 chk("freecnt_two", 32'(freelitcnt_next), 32'd2);
      step();

      var_value_i[5:3] = 3'b101;
      cclause_drv_i = 1;
      step();
      chk("cclause_one", 32'(cclause_o), 32'd1);
      cclause_drv_i = 0;
      step();
      chk("cclause_zero", 32'(cclause_o), 32'd0);

`ifdef LIT_GROUP_ACT_EN
      cclause_drv_i = 1;
      for (int i = 0; i < 5; i++) step();
      chk("act_saturate", 32'(act_o), 32'd3);
      act_clr_i = 1;
      step();
      act_clr_i = 0;
      cclause_drv_i = 0;
      chk("act_clear", 32'(act_o), 32'd0);
      step();
`endif

      wr_i = 1; wr_idx_i = 3'd4; lit_wr_i = 2'b01; clr_i = 1;
      step();
      chk("clr_wins", 32'(lit_o), 32'd0);
      clr_i = 0; wr_idx_i = 3'd5;
      step();
      chk("idx_oob", 32'(lit_o), 32'd0);
      wr_idx_i = 3'd0;
      var_value_i[2:0] = 3'b001;
      step();
      wr_i = 0;
      step();
      chk("pre_reset_sat", 32'(clausesat_o), 32'd1);
      rst = 1'b0;
      #1;
      chk("async_rst_lit", 32'(lit_o), 32'd0);
      chk("async_rst_sat", 32'(clausesat_o), 32'd0);
      chk("async_rst_valid", 32'(valid_o), 32'd0);
      step();
      rst = 1'b1;
      step();

      // randomized phase
      for (int c = 0; c < 3000; c++) begin
         rst            = ($urandom_range(0, 199) != 0);
         wr_i           = ($urandom_range(0, 2) == 0);
         wr_idx_i       = IW'($urandom_range(0, 7));
         lit_wr_i       = 2'($urandom);
         clr_i          = ($urandom_range(0, 15) == 0);
         var_value_i    = (3*N)'($urandom);
         freelitcnt_pre = CW'($urandom);
         imp_drv_i      = 1'($urandom);
         cclause_drv_i  = 1'($urandom);
         act_clr_i      = ($urandom_range(0, 7) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
